// File: rtl/cpu_params.sv
// cpu_params: core-wide sizing constants shared by the front end.
package cpu_params;
  localparam int FETCH_WIDTH = 2;
  localparam int INSTQ_DEPTH = 8;
endpackage

// File: rtl/fetch_types.sv
// fetch_types: packet format produced by fetch and consumed by decode.
package fetch_types;
  import cpu_params::*;
  typedef struct packed {
    logic [31:0]                  pc;
    logic [FETCH_WIDTH-1:0]       valid;
    logic [FETCH_WIDTH-1:0][31:0] insts;
  } fetch_packet_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular fetch-packet FIFO between fetch and decode, flushable on redirect.
// Define INST_QUEUE_BYPASS_EN to let a packet pass straight through when the queue is empty.
module inst_queue
  import cpu_params::*;
  import fetch_types::*;
#(
  parameter int DEPTH = INSTQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fetch_packet_t            in_packet,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fetch_packet_t            out_packet,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_packet_t mem_q [DEPTH];
  logic [AW:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic empty, full, has_insn, push, pop, byp;
  always_comb begin
    empty    = head_q == tail_q;
    full     = head_q[AW-1:0] == tail_q[AW-1:0] && head_q[AW] != tail_q[AW];
    has_insn = |in_packet.valid;
    in_ready = !full && !flush;
`ifdef INST_QUEUE_BYPASS_EN
    byp        = empty && !flush;
    out_valid  = byp ? in_valid && has_insn : !empty && !flush;
    out_packet = byp ? in_packet : mem_q[head_q[AW-1:0]];
    pop        = out_valid && out_ready && !byp;
    push       = in_valid && in_ready && has_insn && !(byp && out_ready);
`else
    byp        = 1'b0;
    out_valid  = !empty && !flush;
    out_packet = mem_q[head_q[AW-1:0]];
    pop        = out_valid && out_ready;
    push       = in_valid && in_ready && has_insn;
`endif
    head_d  = flush ? '0 : head_q + (AW+1)'(pop);
    tail_d  = flush ? '0 : tail_q + (AW+1)'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    count   = count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q[AW-1:0]] <= in_packet;
  end
  logic unused_byp;
  assign unused_byp = byp;
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue (fill, drain, wrap, flush, bubble, latency, reset, random).
module tb_inst_queue;
  import cpu_params::*;
  import fetch_types::*;
  localparam int DEPTH = INSTQ_DEPTH;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [CW-1:0] count;
  fetch_packet_t in_packet, out_packet;
  fetch_packet_t sb [$];
  int n_chk = 0, n_pass = 0;
  inst_queue #(.DEPTH(INSTQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_packet(in_packet), .out_valid(out_valid), .out_ready(out_ready),
    .out_packet(out_packet), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  function automatic fetch_packet_t mk(input logic [31:0] pc, input logic [FETCH_WIDTH-1:0] v);
    fetch_packet_t p;
    p.pc = pc;
    p.valid = v;
    for (int i = 0; i < FETCH_WIDTH; i++) p.insts[i] = pc ^ (32'h13 << i);
    return p;
  endfunction
  task automatic step();
    int n;
    bit acc, pop, has, byp;
    n = sb.size();
    has = |in_packet.valid;
    byp = 0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = n == 0 && !flush;
`endif
    @(negedge clk);
    chk("count", count, n);
    chk("in_ready", in_ready, !flush && n < DEPTH);
    pop = 0;
    if (byp) begin
      chk("byp_out_valid", out_valid, in_valid && has);
      if (in_valid && has) chk("byp_out_packet", out_packet, in_packet);
      acc = in_valid && has && !out_ready;
    end else begin
      chk("out_valid", out_valid, n > 0 && !flush);
      pop = n > 0 && !flush && out_ready;
      if (pop) chk("out_packet", out_packet, sb[0]);
      acc = in_valid && !flush && n < DEPTH && has;
    end
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back(in_packet);
    end
    #1;
  endtask
  initial begin
    logic [31:0] pc;
    in_packet = mk(32'h0, 2'b11);
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    // fill to full, then a 9th offer must be refused
    pc = 32'h6000_0000;
    in_valid = 1;
    for (int i = 0; i < 9; i++) begin in_packet = mk(pc, 2'b11); step(); pc += 4; end
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    // drain in order
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", out_packet.pc, 32'h6000_0000 + 4 * i);
      step();
    end
    step();
    chk("drain_empty", out_valid, 0);
    // wrap-around with simultaneous push and pop at occupancy 4
    out_ready = 0; in_valid = 1; pc = 32'h7000_0000;
    for (int i = 0; i < 4; i++) begin in_packet = mk(pc, 2'b01); step(); pc += 4; end
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin in_packet = mk(pc, 2'b10); step(); pc += 4; end
    chk("wrap_count", count, 4);
    // flush at occupancy 5 with an offer pending
    out_ready = 0; in_packet = mk(pc, 2'b11); step(); pc += 4;
    chk("pre_flush_count", count, 5);
    flush = 1; in_packet = mk(pc, 2'b11); step();
    flush = 0; in_valid = 0; step();
    chk("flush_count", count, 0);
    chk("flush_out_valid", out_valid, 0);
    // bubble drop
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin in_packet = mk(pc, 2'b11); step(); pc += 4; end
    in_packet = mk(pc, 2'b00); step();
    chk("bubble_in_ready_after", in_ready, 1);
    chk("bubble_count", count, 2);
    // latency from empty
    in_valid = 0; out_ready = 1; step(); step();
    in_valid = 1; in_packet = mk(32'h8000_0000, 2'b11); step();
    in_valid = 0; step(); step();
    chk("lat_count", count, 0);
    // mid-stream asynchronous reset
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin in_packet = mk(pc, 2'b11); step(); pc += 4; end
    in_valid = 0;
    @(negedge clk); #2 rst_n = 0; #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    step();
    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      in_packet = mk(pc, 2'($urandom_range(0, 3)));
      pc += 4;
      step();
    end
    flush = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
